axi4_rdch_drop_sender: RTL

//  Read-data-channel counterpart of the RAB write-response drop logic. Reads

---
 rtl/axi4_rdch_drop_sender.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axi4_rdch_drop_sender.sv
// Answers reads that were dropped on the AR side with full-length SLVERR R bursts.
// These bursts share the slave R channel with master-port traffic, and bursts are never interleaved.
module axi4_rdch_drop_sender #(
   parameter int C_AXI_ID_WIDTH   = 10,
   parameter int C_AXI_DATA_WIDTH = 64,
   parameter int C_AXI_USER_WIDTH = 4,
   parameter int C_FIFO_DEPTH     = 4
) (
   input  logic                        axi4_aclk,
   input  logic                        axi4_arstn,
   input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
   input  logic [7:0]                  trans_len,
   input  logic                        trans_drop,
   output logic                        trans_ready,
   output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
   output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
   output logic [1:0]                  s_axi4_rresp,
   output logic                        s_axi4_rlast,
   output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
   output logic                        s_axi4_rvalid,
   input  logic                        s_axi4_rready,
   input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
   input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
   input  logic [1:0]                  m_axi4_rresp,
   input  logic                        m_axi4_rlast,
   input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
   input  logic                        m_axi4_rvalid,
   output logic                        m_axi4_rready
);

   localparam int PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {ST_IDLE, ST_DROP} state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [7:0]           beat_cnt_q, beat_cnt_d;
   logic                 m_burst_active_q, m_burst_active_d;

   logic [C_AXI_ID_WIDTH-1:0] id_mem_q  [C_FIFO_DEPTH];
   logic [7:0]                len_mem_q [C_FIFO_DEPTH];

   logic                      push, pop, m_beat_hs, drop_last;
   logic [C_AXI_ID_WIDTH-1:0] head_id;
   logic [7:0]                head_len;

   assign trans_ready = (count_q != CNT_W'(C_FIFO_DEPTH));
   assign head_id     = id_mem_q[rd_ptr_q];
   assign head_len    = len_mem_q[rd_ptr_q];
   assign drop_last   = (beat_cnt_q == head_len);

   always_comb begin
      push             = trans_drop && trans_ready;
      pop              = 1'b0;
      m_beat_hs        = m_axi4_rvalid && s_axi4_rready;
      state_d          = state_q;
      beat_cnt_d       = beat_cnt_q;
      m_burst_active_d = m_burst_active_q;
      case (state_q)
         ST_IDLE: begin
            if (m_beat_hs && !m_axi4_rlast) m_burst_active_d = 1'b1;
            if (m_beat_hs &&  m_axi4_rlast) m_burst_active_d = 1'b0;
            // A master beat already on the bus is never withdrawn; switch only
            // when the master is quiet or its burst closes this cycle.
            if ((count_q != '0) &&
                ((!m_burst_active_q && !m_axi4_rvalid) || (m_beat_hs && m_axi4_rlast)))
               state_d = ST_DROP;
         end
         ST_DROP: begin
            if (s_axi4_rready) begin
               if (drop_last) begin
                  pop        = 1'b1;
                  beat_cnt_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // R channel: a beat transfers on a rising edge where rvalid && rready; once
   // rvalid is raised the beat and its payload are held until that transfer.
   always_comb begin
      s_axi4_rid    = m_axi4_rid;
      s_axi4_rdata  = m_axi4_rdata;
      s_axi4_rresp  = m_axi4_rresp;
      s_axi4_rlast  = m_axi4_rlast;
      s_axi4_ruser  = m_axi4_ruser;
      s_axi4_rvalid = m_axi4_rvalid;
      m_axi4_rready = s_axi4_rready;
      if (state_q == ST_DROP) begin
         s_axi4_rid    = head_id;
         s_axi4_rdata  = '0;
         s_axi4_rresp  = 2'b10;
         s_axi4_rlast  = drop_last;
         s_axi4_ruser  = '0;
         s_axi4_rvalid = 1'b1;
         m_axi4_rready = 1'b0;
      end
   end

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         state_q          <= ST_IDLE;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         beat_cnt_q       <= '0;
         m_burst_active_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         beat_cnt_q       <= beat_cnt_d;
         m_burst_active_q <= m_burst_active_d;
      end
   end

   // Queue storage needs no reset: entries are only read when count_q says so.
   always_ff @(posedge axi4_aclk) begin
      if (push) begin
         id_mem_q[wr_ptr_q]  <= trans_id;
         len_mem_q[wr_ptr_q] <= trans_len;
      end
   end

endmodule
